// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels, four at a time, into three little-endian 32-bit
// AXI4-Stream words, with sof/eol alignment and line-length checking.
module rgb_stream_packer #(
  parameter int COLOR_WIDTH  = 8,
  parameter int SCREEN_WIDTH = 640
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [COLOR_WIDTH-1:0] r,
  input  logic [COLOR_WIDTH-1:0] g,
  input  logic [COLOR_WIDTH-1:0] b,
  input  logic                   valid,
  input  logic                   sof,
  input  logic                   eol,
  output logic                   in_stream_ready,
  output logic [31:0]            out_stream_tdata,
  output logic [3:0]             out_stream_tkeep,
  output logic                   out_stream_tlast,
  output logic                   out_stream_tuser,
  output logic                   out_stream_tvalid,
  input  logic                   out_stream_tready,
  output logic                   err_sof_misalign,
  output logic                   err_eol_misalign,
  output logic                   err_line_length
);

  if (COLOR_WIDTH != 8) begin : g_bad_color_width
    $error("rgb_stream_packer: only COLOR_WIDTH = 8 is supported");
  end
  if ((SCREEN_WIDTH < 4) || (SCREEN_WIDTH % 4 != 0)) begin : g_bad_screen_width
    $error("rgb_stream_packer: SCREEN_WIDTH must be a multiple of 4 and at least 4");
  end

  localparam int CW = $clog2(SCREEN_WIDTH);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t        r_phase;
  phase_t        w_phase_nxt;
  phase_t        w_phase_eff;
  logic [23:0]   w_pix;
  logic          w_acc;
  logic          w_emit;
  logic [31:0]   w_word;
  logic [23:0]   w_resid_nxt;
  logic          w_sof_pend_eff;
  logic [CW-1:0] w_cnt_eff;

  logic [23:0]   r_residual;
  logic [CW-1:0] r_cnt;
  logic          r_sof_pending;
  logic [31:0]   r_tdata;
  logic          r_tlast;
  logic          r_tuser;
  logic          r_tvalid;
  logic          r_err_sof;
  logic          r_err_eol;
  logic          r_err_len;

  assign w_pix           = {r, g, b};
  assign in_stream_ready = !r_tvalid || out_stream_tready;
  assign w_acc           = valid && in_stream_ready;

  // A sof pixel restarts packing: any partial residual is abandoned and
  // the pixel is handled as phase 0 of a fresh line.
  assign w_phase_eff    = sof ? PH0 : r_phase;
  assign w_sof_pend_eff = sof || r_sof_pending;
  assign w_cnt_eff      = sof ? '0 : r_cnt;

  always_ff @(posedge aclk) begin
    if (areset) r_phase <= PH0;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_acc) begin
      if (eol) begin
        w_phase_nxt = PH0;
      end else begin
        case (w_phase_eff)
          PH0:     w_phase_nxt = PH1;
          PH1:     w_phase_nxt = PH2;
          PH2:     w_phase_nxt = PH3;
          default: w_phase_nxt = PH0;
        endcase
      end
    end
  end

  always_comb begin
    w_emit      = 1'b0;
    w_word      = '0;
    w_resid_nxt = r_residual;
    if (w_acc) begin
      case (w_phase_eff)
        PH0: begin
          if (eol) begin
            w_emit = 1'b1;
            w_word = {8'h00, w_pix};
          end else begin
            w_resid_nxt = w_pix;
          end
        end
        PH1: begin
          w_emit = 1'b1;
          w_word = {w_pix[7:0], r_residual};
          if (!eol) w_resid_nxt[15:0] = w_pix[23:8];
        end
        PH2: begin
          w_emit = 1'b1;
          w_word = {w_pix[15:0], r_residual[15:0]};
          if (!eol) w_resid_nxt[7:0] = w_pix[23:16];
        end
        default: begin
          w_emit = 1'b1;
          w_word = {w_pix, r_residual[7:0]};
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_residual    <= '0;
      r_cnt         <= '0;
      r_sof_pending <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_tvalid      <= 1'b0;
      r_err_sof     <= 1'b0;
      r_err_eol     <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_residual    <= w_resid_nxt;
        r_sof_pending <= w_emit ? 1'b0 : w_sof_pend_eff;
        r_cnt         <= eol ? '0 : w_cnt_eff + CW'(1);
        if (sof && (r_phase != PH0))                   r_err_sof <= 1'b1;
        if (eol && (w_phase_eff != PH3))               r_err_eol <= 1'b1;
        if (eol && (w_cnt_eff != CW'(SCREEN_WIDTH-1))) r_err_len <= 1'b1;
      end
      // A new word may replace one that is handshaking on this same edge.
      if (w_emit) begin
        r_tdata  <= w_word;
        r_tlast  <= eol;
        r_tuser  <= w_sof_pend_eff;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && out_stream_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign out_stream_tdata  = r_tdata;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tlast  = r_tlast;
  assign out_stream_tuser  = r_tuser;
  assign out_stream_tvalid = r_tvalid;
  assign err_sof_misalign  = r_err_sof;
  assign err_eol_misalign  = r_err_eol;
  assign err_line_length   = r_err_len;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: directed scenarios followed by random lines,
// checked against a byte-stream reference model.
module tb_rgb_stream_packer;

  localparam int SW = 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready;
  logic        err_sof_misalign, err_eol_misalign, err_line_length;

  rgb_stream_packer #(.COLOR_WIDTH(8), .SCREEN_WIDTH(SW)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .err_sof_misalign  (err_sof_misalign),
    .err_eol_misalign  (err_eol_misalign),
    .err_line_length   (err_line_length)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
  } word_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  word_t      exp_q[$];
  word_t      obs_q[$];
  logic [7:0] m_bytes[$];
  logic       m_pend, m_esof, m_eeol, m_elen;
  int         m_cnt;

  localparam logic [23:0] P0 = 24'h112233;
  localparam logic [23:0] P1 = 24'h445566;
  localparam logic [23:0] P2 = 24'h778899;
  localparam logic [23:0] P3 = 24'hAABBCC;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic m_clear();
    exp_q.delete();
    m_bytes.delete();
    m_pend = 1'b0; m_esof = 1'b0; m_eeol = 1'b0; m_elen = 1'b0;
    m_cnt  = 0;
  endtask

  // Reference: pixels become a little-endian byte stream; every 4 bytes form
  // a word; eol closes the line with exactly one tlast word (zero-padded if
  // no full word formed) and drops leftover bytes.
  task automatic m_accept(input logic [23:0] p, input logic s, input logic e);
    word_t w;
    logic  emitted;
    if (s) begin
      if (m_bytes.size() != 0) m_esof = 1'b1;
      m_bytes.delete();
      m_pend = 1'b1;
      m_cnt  = 0;
    end
    m_bytes.push_back(p[7:0]);
    m_bytes.push_back(p[15:8]);
    m_bytes.push_back(p[23:16]);
    m_cnt++;
    emitted = 1'b0;
    if (m_bytes.size() >= 4) begin
      w.d = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      repeat (4) void'(m_bytes.pop_front());
      w.l = 1'b0;
      w.u = m_pend;
      m_pend = 1'b0;
      exp_q.push_back(w);
      emitted = 1'b1;
    end
    if (e) begin
      if (m_bytes.size() != 0) m_eeol = 1'b1;
      if (!emitted) begin
        w.d = '0;
        for (int i = 0; i < m_bytes.size(); i++) w.d[8*i +: 8] = m_bytes[i];
        w.l = 1'b1;
        w.u = m_pend;
        m_pend = 1'b0;
        exp_q.push_back(w);
      end else begin
        exp_q[exp_q.size()-1].l = 1'b1;
      end
      m_bytes.delete();
      if (m_cnt != SW) m_elen = 1'b1;
      m_cnt = 0;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance.
  task automatic tick(input logic v, input logic [23:0] p, input logic s, input logic e,
                      input logic rdy, output logic acc);
    logic exp_rdy;
    word_t w;
    valid = v; {r, g, b} = p; sof = s; eol = e; out_stream_tready = rdy;
    #1;
    chk("tvalid", out_stream_tvalid, (exp_q.size() != 0));
    chk("flags", {err_sof_misalign, err_eol_misalign, err_line_length},
        {m_esof, m_eeol, m_elen});
    exp_rdy = (exp_q.size() == 0) || rdy;
    chk("in_ready", in_stream_ready, exp_rdy);
    if (out_stream_tvalid && exp_q.size() != 0) begin
      chk("word", {out_stream_tdata, out_stream_tlast, out_stream_tuser},
          {exp_q[0].d, exp_q[0].l, exp_q[0].u});
      chk("tkeep", out_stream_tkeep, 4'hF);
      if (rdy) begin
        w.d = out_stream_tdata; w.l = out_stream_tlast; w.u = out_stream_tuser;
        obs_q.push_back(w);
        void'(exp_q.pop_front());
      end
    end
    acc = v && exp_rdy;
    if (acc) m_accept(p, s, e);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // rmode: 0 tready low, 1 tready high, 2 random tready and valid gaps
  task automatic send(input logic [23:0] p, input logic s, input logic e, input int rmode);
    logic acc, v, rdy;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      v   = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = (rmode == 2) ? ($urandom_range(0, 3) != 0) : (rmode == 1);
      tick(v, p, s, e, rdy, acc);
    end
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 24'h0, 1'b0, 1'b0, rdy, acc);
  endtask

  task automatic do_reset();
    valid = 1'b0; sof = 1'b0; eol = 1'b0; out_stream_tready = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    m_clear();
    #1;
    chk("rst_tvalid", out_stream_tvalid, 1'b0);
    chk("rst_out", {out_stream_tdata, out_stream_tlast, out_stream_tuser}, '0);
    chk("rst_flags", {err_sof_misalign, err_eol_misalign, err_line_length}, 3'b000);
    chk("rst_ready", in_stream_ready, 1'b1);
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic [31:0] d,
                         input logic l, input logic u);
    if (idx < obs_q.size())
      chk(tag, {obs_q[idx].d, obs_q[idx].l, obs_q[idx].u}, {d, l, u});
    else
      chk({tag, "_missing"}, obs_q.size(), idx + 1);
  endtask

  initial begin
    logic acc;
    int   len, sofpos;
    areset = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0; out_stream_tready = 1'b0;
    r = '0; g = '0; b = '0;
    m_clear();
    @(negedge aclk);
    do_reset();

    // Basic packing, then completing an 8-pixel line
    obs_q.delete();
    send(P0, 1'b1, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    send(P2, 1'b0, 1'b0, 1); send(P3, 1'b0, 1'b0, 1);
    send(P0, 1'b0, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    send(P2, 1'b0, 1'b0, 1); send(P3, 1'b0, 1'b1, 1);
    idle(3, 1'b1);
    chk_obs("basic_w0", 0, 32'h66112233, 1'b0, 1'b1);
    chk_obs("basic_w1", 1, 32'h88994455, 1'b0, 1'b0);
    chk_obs("basic_w2", 2, 32'hAABBCC77, 1'b0, 1'b0);
    chk_obs("line_w5", 5, 32'hAABBCC77, 1'b1, 1'b0);
    chk("line_words", obs_q.size(), 6);
    chk("line_len_err", err_line_length, 1'b0);

    // Backpressure mid-line
    do_reset();
    obs_q.delete();
    send(P0, 1'b1, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, P2, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_stall", acc, 1'b0);
    end
    send(P2, 1'b0, 1'b0, 1); send(P3, 1'b0, 1'b0, 1);
    idle(3, 1'b1);
    chk("bp_words", obs_q.size(), 3);
    chk_obs("bp_w0", 0, 32'h66112233, 1'b0, 1'b1);
    chk_obs("bp_w2", 2, 32'hAABBCC77, 1'b0, 1'b0);

    // Misaligned eol
    do_reset();
    obs_q.delete();
    send(P0, 1'b1, 1'b0, 1); send(P1, 1'b0, 1'b1, 1);
    send(P0, 1'b0, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    idle(3, 1'b1);
    chk_obs("eol_w0", 0, 32'h66112233, 1'b1, 1'b1);
    chk_obs("eol_w1", 1, 32'h66112233, 1'b0, 1'b0);
    chk("eol_flag", err_eol_misalign, 1'b1);

    // Misaligned sof
    do_reset();
    obs_q.delete();
    send(P0, 1'b1, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    send(P2, 1'b1, 1'b0, 1); send(P3, 1'b0, 1'b0, 1);
    idle(3, 1'b1);
    chk_obs("sof_w1", 1, 32'hCC778899, 1'b0, 1'b1);
    chk("sof_flag", err_sof_misalign, 1'b1);

    // Reset while a word is held by backpressure
    do_reset();
    send(P0, 1'b1, 1'b0, 0); send(P1, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    do_reset();
    obs_q.delete();
    send(P0, 1'b1, 1'b0, 1); send(P1, 1'b0, 1'b0, 1);
    send(P2, 1'b0, 1'b0, 1); send(P3, 1'b0, 1'b0, 1);
    idle(3, 1'b1);
    chk("rst_words", obs_q.size(), 3);
    chk_obs("rst_w0", 0, 32'h66112233, 1'b0, 1'b1);

    // Random lines: mostly full length, some short/long, occasional stray sof
    do_reset();
    for (int l = 0; l < 40; l++) begin
      len    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : SW;
      sofpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1))
                                           : ((l % 4 == 0) ? 0 : -1);
      for (int i = 0; i < len; i++)
        send(24'($urandom), (i == sofpos), (i == len - 1), 2);
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
